// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Shared feature-map geometry and channel vector type for the CNN datapath.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

    localparam int CONV1_OUT_W = 26;
    localparam int CONV1_OUT_H = 26;
    localparam int CONV1_CH    = 8;
    localparam int POOL1_OUT_W = 13;
    localparam int POOL1_OUT_H = 13;

    typedef logic [CONV1_CH-1:0] ch_vec_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/maxpool1_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : maxpool1_linebuf
// One-row store of horizontally pooled pairs: DEPTH x CH registers,
// one write port and one combinational read port.
// Revision : 1.0
// ============================================================================
module maxpool1_linebuf #(
    parameter int DEPTH  = 13,
    parameter int CH     = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [CH-1:0]     i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [CH-1:0]     o_rd_data
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [CH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The trailing column of an odd-width map addresses one past the end.
    assign o_rd_data = ({1'b0, i_rd_addr} < c_depth) ? r_mem[i_rd_addr] : '0;

endmodule : maxpool1_linebuf
`default_nettype wire

// File: rtl/maxpool1_layer.sv
`default_nettype none
// ============================================================================
// Module   : maxpool1_layer
// 2x2 stride-2 binary max-pool (per-channel OR) after conv layer 1.
// Optional macro MAXPOOL1_FRAME_DONE_EN adds a frame_done pulse output.
// Revision : 1.0
// ============================================================================
module maxpool1_layer
    import cnn_pkg::*;
#(
    parameter int WIDTH  = CONV1_OUT_W,
    parameter int HEIGHT = CONV1_OUT_H,
    parameter int CH     = CONV1_CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] conv1_in,
    input  logic          valid_in,
    output logic [CH-1:0] pool1_out,
    output logic          valid_out_pool1
`ifdef MAXPOOL1_FRAME_DONE_EN
    ,
    output logic          frame_done
`endif
);

    localparam int c_col_w  = $clog2(WIDTH);
    localparam int c_row_w  = $clog2(HEIGHT);
    localparam int c_depth  = WIDTH / 2;
    localparam int c_addr_w = (c_depth > 1) ? $clog2(c_depth) : 1;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(HEIGHT - 1);

    logic [c_col_w-1:0]  r_col_cnt;
    logic [c_row_w-1:0]  r_row_cnt;
    logic [CH-1:0]       r_h_reg;
    logic [CH-1:0]       w_buf_rd;
    logic [c_addr_w-1:0] w_pair_idx;
    logic                w_buf_wr;
    logic                w_window_done;

    assign w_pair_idx    = c_addr_w'(r_col_cnt >> 1);
    assign w_buf_wr      = valid_in &  r_col_cnt[0] & ~r_row_cnt[0];
    assign w_window_done = valid_in &  r_col_cnt[0] &  r_row_cnt[0];

    maxpool1_linebuf #(
        .DEPTH  (c_depth),
        .CH     (CH),
        .ADDR_W (c_addr_w)
    ) u_linebuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_buf_wr),
        .i_wr_addr (w_pair_idx),
        .i_wr_data (r_h_reg | conv1_in),
        .i_rd_addr (w_pair_idx),
        .o_rd_data (w_buf_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_cnt       <= '0;
            r_row_cnt       <= '0;
            r_h_reg         <= '0;
            pool1_out       <= '0;
            valid_out_pool1 <= 1'b0;
        end else begin
            valid_out_pool1 <= w_window_done;
            if (w_window_done) begin
                pool1_out <= r_h_reg | conv1_in | w_buf_rd;
            end
            if (valid_in) begin
                if (!r_col_cnt[0]) begin
                    r_h_reg <= conv1_in;
                end
                if (r_col_cnt == c_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= (r_row_cnt == c_row_last) ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
        end
    end

`ifdef MAXPOOL1_FRAME_DONE_EN
    // Last window closes on the final odd row/column; trailing odd lines never form one.
    localparam logic [c_col_w-1:0] c_col_win_last = c_col_w'(2 * (WIDTH / 2) - 1);
    localparam logic [c_row_w-1:0] c_row_win_last = c_row_w'(2 * (HEIGHT / 2) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_window_done
                          && (r_col_cnt == c_col_win_last)
                          && (r_row_cnt == c_row_win_last);
        end
    end
`endif

endmodule : maxpool1_layer
`default_nettype wire
